countdown_timer: RTL and testbench
==================================

# countdown_timer

Minutes:seconds countdown timer: the count-down, borrow-chained counterpart of the clock's roll-over counter chain. It loads a preset, decrements once per 1 Hz tick, and cascades seconds into minutes through a borrow rather than a carry. It asserts a one-cycle `done` pulse when 00:00 is reached. It sits beside the time-of-day counters, shares their tick source, and feeds the same seven-segment display mux.

## Interface
Parameters:
- `MAX_MIN`, default 59: largest loadable minutes value; wider presets are clamped.
- `MAX_SEC`, fixed 59: seconds modulus minus one; not overridable.

Ports:
- `clk` in, 1: system clock.
- `reset_n` in, 1: reset, asynchronous, active-low.
- `tick` in, 1: one-`clk`-cycle enable at 1 Hz.
- `load` in, 1: load the preset.
- `load_min` in, 6: minutes preset.
- `load_sec` in, 6: seconds preset.
- `start` in, 1: level-sampled run request.
- `stop` in, 1: level-sampled pause request.
- `min` out, 6: current minutes.
- `sec` out, 6: current seconds.
- `running` out, 1: high in state RUN.
- `borrow` out, 1: one-cycle pulse when seconds wrap 0→59.
- `done` out, 1: one-cycle pulse on reaching 00:00.

## Operation
State machine states:
- IDLE: reset state. Counters hold.
- RUN: decrement on `tick`.
- PAUSE: hold value.
- EXPIRED: hold 00:00.

Transitions, evaluated on each `clk` edge, in priority order:
- `load` from any state → IDLE. `min` := min(`load_min`, `MAX_MIN`). `sec` := min(`load_sec`, 59).
- `stop` in RUN → PAUSE.
- `start` in IDLE or PAUSE → RUN, but only if the count ≠ 00:00. Otherwise stay put.
- RUN with `tick`:
  - if `sec` > 0: `sec`−1.
  - else if `min` > 0: `sec` := 59, `min`−1, pulse `borrow`.
  - the step that produces 00:00 pulses `done` and moves to EXPIRED.
- EXPIRED → RUN on `start` only after a new `load` has made the count nonzero; a bare `start` is ignored.

Arithmetic and width rules:
- All arithmetic is unsigned 6-bit.
- Decrement never underflows, because 00:00 is never decremented.

Simultaneous and boundary events:
- `load` together with `tick`: `load` wins and the tick is dropped.
- `start` together with `stop`: `stop` wins.
- `tick` in the same cycle as the transition into RUN: not counted. The first decrement comes on the next `tick`.
- Preset 00:00 and `start`: no RUN, no `done`.

## Timing
- Reset values: state IDLE, `min`=0, `sec`=0, `running`=0, `borrow`=0, `done`=0.
- Reset asserts asynchronously and releases synchronously to `clk` edges.
- All outputs are registered. Value updates appear one `clk` after the qualifying `tick`.
- `done` and `borrow` are high for exactly one `clk` cycle, in the same cycle as the counter update that caused them.
- `running` follows the state register with no extra latency.
- `reset_n` low mid-count clears everything immediately. No pulses are emitted during or after reset.

## Configuration
- `COUNTDOWN_AUTORELOAD_EN` defined:
  - the last preset loaded is stored.
  - on expiry, `done` pulses and the preset is reloaded into `min`/`sec` in the same cycle.
  - the state stays in RUN; EXPIRED is unreachable.
  - a 00:00 preset still blocks RUN.
- Undefined: behaviour as described above. The preset storage registers are not synthesised.

## Structure
- Shared package `clock_pkg` holds:
  - the state enum: IDLE, RUN, PAUSE, EXPIRED.
  - `SEC_MAX` = 59.
  - the 6-bit field width constant.
- One sub-module, `count_down_mod`:
  - parameterised modulus, down-counter digit.
  - inputs: `en`, `load`, `load_val`.
  - outputs: `q` and `borrow_out`, where `borrow_out` is high when `en` and `q`==0.
- The seconds instance is enabled by `tick` in RUN. The minutes instance is enabled by the seconds `borrow_out`. `done` detection is done in the parent.

## Test plan
- Reset then idle: `reset_n` low mid-RUN at 03:17 → all outputs 0 at once, state IDLE, no `done`.
- Load 00:03, `start`, 3 ticks → `sec` goes 2, 1, 0. `done` pulses on the third tick and is high 1 cycle. `running` falls. Further ticks leave 00:00.
- Load 02:00, `start`, 1 tick → 01:59 with `borrow` pulse. 120 ticks total → `done` exactly once.
- Load 00:10, `start`, 4 ticks, `stop`, 5 ticks, `start`, 6 ticks → 00:00 and `done`. Ticks during PAUSE are ignored.
- Boundaries:
  - `load` 63:63 with `MAX_MIN`=59 → 59:59.
  - `load` coincident with `tick` in RUN → new preset, no decrement.
  - 00:00 then `start` → stays IDLE.
- `COUNTDOWN_AUTORELOAD_EN` defined, load 00:02, run 6 ticks → `done` pulses at ticks 2, 4 and 6. Value reloads to 00:02 each time and `running` stays high.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// clock_pkg: definitions shared by the clock counter chain and the countdown timer.
//   state_t     - countdown timer state machine encoding
//   FIELD_W     - width of a minutes or seconds field
//   SEC_MAX     - largest seconds value (modulus 60)
//   clamp_field - limits a preset field to a maximum value
package clock_pkg;

    localparam int FIELD_W = 6;
    localparam logic [FIELD_W-1:0] SEC_MAX = 6'd59;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    function automatic logic [FIELD_W-1:0] clamp_field(input logic [FIELD_W-1:0] v,
                                                       input logic [FIELD_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control and status bundle of the countdown timer.
//   tick, load, load_min, load_sec, start, stop : requests toward the timer
//   min, sec, running, borrow, done             : timer status
// modport master drives the requests, modport slave is the timer side.
interface countdown_timer_if;

    logic                          tick;
    logic                          load;
    logic [clock_pkg::FIELD_W-1:0] load_min;
    logic [clock_pkg::FIELD_W-1:0] load_sec;
    logic                          start;
    logic                          stop;
    logic [clock_pkg::FIELD_W-1:0] min;
    logic [clock_pkg::FIELD_W-1:0] sec;
    logic                          running;
    logic                          borrow;
    logic                          done;

    modport master (
        output tick, load, load_min, load_sec, start, stop,
        input  min, sec, running, borrow, done
    );

    modport slave (
        input  tick, load, load_min, load_sec, start, stop,
        output min, sec, running, borrow, done
    );

endinterface

// File: rtl/countdown_timer_count_down_mod.sv
// count_down_mod: one down-counting digit of modulus MODULUS.
//   clk, reset_n : clock, async active-low reset
//   en           : decrement this cycle (wraps 0 -> MODULUS-1)
//   load         : load load_val (has priority over en)
//   q            : current value
//   borrow_out   : high while en is set and q is 0, i.e. the next digit must decrement
module count_down_mod
    import clock_pkg::*;
#(
    parameter int MODULUS = 60
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               load,
    input  logic [FIELD_W-1:0] load_val,
    output logic [FIELD_W-1:0] q,
    output logic               borrow_out
);

    localparam logic [FIELD_W-1:0] Q_TOP = FIELD_W'(MODULUS - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= (q == '0) ? Q_TOP : q - FIELD_W'(1);
        end
    end

    assign borrow_out = en && (q == '0);

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: minutes:seconds countdown with borrow chaining and a done pulse.
//   clk     : system clock
//   reset_n : async active-low reset
//   bus     : countdown_timer_if.slave (tick/load/presets/start/stop in,
//             min/sec/running/borrow/done out)
// Build option: COUNTDOWN_AUTORELOAD_EN reloads the last preset on expiry and keeps running.
//
// state   | meaning
// IDLE    | reset or freshly loaded, counters hold
// RUN     | decrement on each tick
// PAUSE   | stopped by the user, counters hold
// EXPIRED | reached 00:00, holds until the next load
module countdown_timer
    import clock_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic            clk,
    input  logic            reset_n,
    countdown_timer_if.slave bus
);

    localparam logic [FIELD_W-1:0] MIN_LIM = FIELD_W'(MAX_MIN);

`ifdef COUNTDOWN_AUTORELOAD_EN
    localparam bit AUTORELOAD = 1'b1;
`else
    localparam bit AUTORELOAD = 1'b0;
`endif

    state_t             state, state_nxt;
    logic [FIELD_W-1:0] sec_q, min_q;
    logic [FIELD_W-1:0] clamp_min, clamp_sec;
    logic [FIELD_W-1:0] sec_load_val, min_load_val;
    logic               sec_load, min_load;
    logic               nonzero, run_tick, final_step;
    logic               sec_borrow, min_borrow_unused;
    logic               borrow_q, done_q;

    assign clamp_min = clamp_field(bus.load_min, MIN_LIM);
    assign clamp_sec = clamp_field(bus.load_sec, SEC_MAX);

    assign nonzero = (min_q != '0) || (sec_q != '0);
    // load and stop both outrank a tick, so such a tick is simply lost
    assign run_tick = (state == RUN) && bus.tick && !bus.load && !bus.stop;
    // in RUN the count is never 00:00, so only x:01 with zero minutes reaches it
    assign final_step = run_tick && (min_q == '0) && (sec_q == FIELD_W'(1));

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [FIELD_W-1:0] preset_min, preset_sec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            preset_min <= '0;
            preset_sec <= '0;
        end else if (bus.load) begin
            preset_min <= clamp_min;
            preset_sec <= clamp_sec;
        end
    end

    // the expiring step loads the stored preset instead of landing on 00:00
    assign sec_load     = bus.load || final_step;
    assign min_load     = bus.load || final_step;
    assign sec_load_val = bus.load ? clamp_sec : preset_sec;
    assign min_load_val = bus.load ? clamp_min : preset_min;
`else
    assign sec_load     = bus.load;
    assign min_load     = bus.load;
    assign sec_load_val = clamp_sec;
    assign min_load_val = clamp_min;
`endif

    count_down_mod #(.MODULUS(int'(SEC_MAX) + 1)) u_sec (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (run_tick),
        .load       (sec_load),
        .load_val   (sec_load_val),
        .q          (sec_q),
        .borrow_out (sec_borrow)
    );

    count_down_mod #(.MODULUS(MAX_MIN + 1)) u_min (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (sec_borrow),
        .load       (min_load),
        .load_val   (min_load_val),
        .q          (min_q),
        .borrow_out (min_borrow_unused)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            borrow_q <= sec_borrow;
            done_q   <= final_step;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.load) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                RUN: begin
                    if (bus.stop) begin
                        state_nxt = PAUSE;
                    end else if (final_step && !AUTORELOAD) begin
                        state_nxt = EXPIRED;
                    end
                end
                // EXPIRED always holds 00:00 here, so only a load reopens it
                IDLE, PAUSE, EXPIRED: begin
                    if (bus.start && !bus.stop && nonzero) begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.min     = min_q;
    assign bus.sec     = sec_q;
    assign bus.running = (state == RUN);
    assign bus.borrow  = borrow_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int MAXM = 59;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    countdown_timer_if bus();

    countdown_timer #(.MAX_MIN(MAXM)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: count held as total seconds
    int m_total  = 0;
    int m_preset = 0;
    int m_mode   = M_IDLE;
    bit m_done   = 1'b0;
    bit m_borrow = 1'b0;
    int done_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int lim(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic void model_step(input bit t, input bit l, input int lm, input int ls,
                                       input bit st, input bit sp);
        m_done   = 1'b0;
        m_borrow = 1'b0;
        if (l) begin
            m_total  = lim(lm, MAXM) * 60 + lim(ls, 59);
            m_preset = m_total;
            m_mode   = M_IDLE;
        end else if (m_mode == M_RUN && sp) begin
            m_mode = M_PAUSE;
        end else if ((m_mode == M_IDLE || m_mode == M_PAUSE) && st && !sp && m_total != 0) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN && t) begin
            if (m_total % 60 == 0) m_borrow = 1'b1;
            m_total = m_total - 1;
            if (m_total == 0) begin
                m_done = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                m_total = m_preset;
`else
                m_mode = M_EXP;
`endif
            end
        end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".min"},     32'(bus.min),     32'(m_total / 60));
        check({tag, ".sec"},     32'(bus.sec),     32'(m_total % 60));
        check({tag, ".running"}, 32'(bus.running), 32'(m_mode == M_RUN));
        check({tag, ".borrow"},  32'(bus.borrow),  32'(m_borrow));
        check({tag, ".done"},    32'(bus.done),    32'(m_done));
        if (bus.done === 1'b1) done_seen++;
    endtask

    task automatic cyc(input string tag, input bit t, input bit l, input int lm, input int ls,
                       input bit st, input bit sp);
        bus.tick     = t;
        bus.load     = l;
        bus.load_min = 6'(lm);
        bus.load_sec = 6'(ls);
        bus.start    = st;
        bus.stop     = sp;
        model_step(t, l, lm, ls, st, sp);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic tick_gap(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(tag, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
            cyc(tag, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        bus.tick = 1'b0; bus.load = 1'b0; bus.load_min = '0; bus.load_sec = '0;
        bus.start = 1'b0; bus.stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        reset_n = 1'b1;
        cyc("idle", 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

        // async reset mid-run at 03:17
        cyc("ld317", 1'b0, 1'b1, 3, 17, 1'b0, 1'b0);
        cyc("st317", 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        tick_gap("run317", 2);
        #2 reset_n = 1'b0;
        #1;
        m_total = 0; m_mode = M_IDLE; m_done = 1'b0; m_borrow = 1'b0;
        compare_all("rst_async");
        @(posedge clk);
        #1;
        compare_all("rst_hold");
        reset_n = 1'b1;
        cyc("rst_rel", 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);

        // 00:03 runs out on the third tick
        cyc("ld003", 1'b0, 1'b1, 0, 3, 1'b0, 1'b0);
        cyc("st003", 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
`ifndef COUNTDOWN_AUTORELOAD_EN
        done_seen = 0;
        tick_gap("run003", 5);
        check("done003_count", 32'(done_seen), 32'd1);
        check("exp_bare_start_sec", 32'(bus.sec), 32'd0);
        cyc("exp_start", 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        check("exp_start_running", 32'(bus.running), 32'd0);

        // 02:00 borrows into 01:59, then done exactly once over 120 ticks
        cyc("ld200", 1'b0, 1'b1, 2, 0, 1'b0, 1'b0);
        cyc("st200", 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        done_seen = 0;
        cyc("tick200", 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        check("borrow200", 32'(bus.borrow), 32'd1);
        check("min200", 32'(bus.min), 32'd1);
        for (int i = 1; i < 120; i++) cyc("run200", 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        check("done200_count", 32'(done_seen), 32'd1);

        // pause ignores ticks
        cyc("ld010", 1'b0, 1'b1, 0, 10, 1'b0, 1'b0);
        cyc("st010", 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        tick_gap("run010a", 4);
        cyc("stop010", 1'b1, 1'b0, 0, 0, 1'b1, 1'b1);
        tick_gap("pause010", 5);
        check("pause_sec", 32'(bus.sec), 32'd6);
        done_seen = 0;
        cyc("rest010", 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        tick_gap("run010b", 6);
        check("done010_count", 32'(done_seen), 32'd1);
`endif

        // clamp, load vs tick, zero preset
        cyc("ld6363", 1'b0, 1'b1, 63, 63, 1'b0, 1'b0);
        check("clamp_min", 32'(bus.min), 32'd59);
        check("clamp_sec", 32'(bus.sec), 32'd59);
        cyc("st5959", 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        tick_gap("run5959", 2);
        cyc("ld_tick", 1'b1, 1'b1, 1, 30, 1'b0, 1'b0);
        check("ld_tick_sec", 32'(bus.sec), 32'd30);
        cyc("ld000", 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        cyc("st000", 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        check("zero_no_run", 32'(bus.running), 32'd0);

`ifdef COUNTDOWN_AUTORELOAD_EN
        cyc("ar_ld", 1'b0, 1'b1, 0, 2, 1'b0, 1'b0);
        cyc("ar_st", 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        done_seen = 0;
        for (int i = 1; i <= 6; i++) begin
            cyc("ar_tick", 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
            check("ar_done_at_tick", 32'(bus.done), 32'((i % 2) == 0));
            check("ar_running", 32'(bus.running), 32'd1);
        end
        check("ar_done_count", 32'(done_seen), 32'd3);
        check("ar_reload_sec", 32'(bus.sec), 32'd2);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit t, l, st, sp;
            int lm, ls;
            t  = ($urandom_range(0, 2) == 0);
            l  = ($urandom_range(0, 39) == 0);
            lm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 1));
            ls = int'($urandom_range(0, 63));
            st = ($urandom_range(0, 3) == 0);
            sp = ($urandom_range(0, 15) == 0);
            cyc("rand", t, l, lm, ls, st, sp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
